// File: rtl/lsu_controller_pkg.sv
// lsu_controller_pkg
//   Shared encodings for the memory-stage controller: instruction type,
//   access size, FSM state and the AXI-lite OKAY response code.
//   Also holds the alignment and byte-strobe helpers, which are used by both
//   the accept decision and the store path.
package lsu_controller_pkg;

  typedef enum logic [1:0] {
    INST_ALU   = 2'b00,
    INST_LOAD  = 2'b01,
    INST_STORE = 2'b10,
    INST_RSVD  = 2'b11   // behaves as ALU
  } inst_type_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11    // behaves as word
  } mem_size_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_HOLD    = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Half needs addr[0]==0; word (and the reserved size) needs addr[1:0]==0.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = off[0];
      default:   misaligned = (off != 2'b00);
    endcase
  endfunction

  // Byte strobe for the access size before it is shifted to the lane offset.
  function automatic logic [3:0] size_strb(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_strb = 4'b0001;
      SIZE_HALF: size_strb = 4'b0011;
      default:   size_strb = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_controller_load_align.sv
// lsu_load_align
//   Combinational load-data aligner. Moves the addressed byte/half/word of
//   the 32-bit bus word down to bit 0 and then sign- or zero-extends it.
//   Ports: rdata_i (bus word), offset_i (addr[1:0]), size_i (mem_size code),
//          unsigned_i (zero-extend), result_o (32-bit writeback value).
module lsu_load_align
  import lsu_controller_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    result_o = shifted;
    case (size_i)
      SIZE_BYTE: result_o = unsigned_i ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: result_o = unsigned_i ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default:   result_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// lsu_controller
//   Memory stage of the pipelined core. Accepts one instruction from execute
//   (valid_pre_i/ready_pre_o), runs an AXI-lite read or write for loads and
//   stores, then offers the result to commit (valid_post_o/ready_post_i).
//   Ports:
//     clock, reset           : clock, synchronous active-high reset
//     *_pre / inst inputs    : instruction from execute
//     ar*/r*                 : AXI-lite read address / data channels
//     aw*/w*/b*              : AXI-lite write address / data / response channels
//     *_post, result_o, rd_o, wen_o, mem_err_o : result to commit
module lsu_controller
  import lsu_controller_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // only 32 is supported
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_pre_i,
  output logic              ready_pre_o,
  input  logic [1:0]        inst_type_i,
  input  logic [1:0]        mem_size_i,
  input  logic              load_unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        rd_i,
  input  logic              wen_i,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [3:0]        wstrb_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o,
  output logic              valid_post_o,
  input  logic              ready_post_i,
  output logic [DATA_W-1:0] result_o,
  output logic [4:0]        rd_o,
  output logic              wen_o,
  output logic              mem_err_o
);

  state_e            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic              wen_in_q, wen_in_d;   // wen from execute, used if the load succeeds
  logic [DATA_W-1:0] result_q, result_d;
  logic              wb_wen_q, wb_wen_d;   // wen presented to commit
  logic              err_q, err_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic [DATA_W-1:0] load_data;
  logic              is_mem;

  lsu_load_align u_load_align (
    .rdata_i    (rdata_i),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .result_o   (load_data)
  );

  // Bus addresses are word aligned; the byte lanes are selected by wstrb
  // on writes and by the aligner on reads.
  assign araddr_o = {addr_q[ADDR_W-1:2], 2'b00};
  assign awaddr_o = {addr_q[ADDR_W-1:2], 2'b00};
  assign wdata_o  = wdata_q << {addr_q[1:0], 3'b000};
  assign wstrb_o  = size_strb(size_q) << addr_q[1:0];

  assign result_o  = result_q;
  assign rd_o      = rd_q;
  assign wen_o     = wb_wen_q;
  assign mem_err_o = err_q;

  assign is_mem = (inst_type_i == INST_LOAD) || (inst_type_i == INST_STORE);

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wen_in_d     = wen_in_q;
    result_d     = result_q;
    wb_wen_d     = wb_wen_q;
    err_d        = err_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    ready_pre_o  = 1'b0;
    arvalid_o    = 1'b0;
    rready_o     = 1'b0;
    awvalid_o    = 1'b0;
    wvalid_o     = 1'b0;
    bready_o     = 1'b0;
    valid_post_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_pre_o = 1'b1;
        if (valid_pre_i) begin
          size_d    = mem_size_i;
          uns_d     = load_unsigned_i;
          addr_d    = addr_i;
          wdata_d   = wdata_i;
          rd_d      = rd_i;
          wen_in_d  = wen_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          result_d  = '0;
          wb_wen_d  = 1'b0;
          err_d     = 1'b0;
          if (is_mem && misaligned(mem_size_i, addr_i[1:0])) begin
            err_d   = 1'b1;
            state_d = S_HOLD;
          end else if (inst_type_i == INST_LOAD) begin
            state_d = S_RD_ADDR;
          end else if (inst_type_i == INST_STORE) begin
            state_d = S_WR_REQ;
          end else begin
            result_d = alu_result_i;
            wb_wen_d = wen_i;
            state_d  = S_HOLD;
          end
        end
      end

      S_RD_ADDR: begin
        arvalid_o = 1'b1;
        if (arready_i) state_d = S_RD_DATA;
      end

      S_RD_DATA: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          if (rresp_i == RESP_OKAY) begin
            result_d = load_data;
            wb_wen_d = wen_in_q;
          end else begin
            result_d = '0;
            wb_wen_d = 1'b0;
            err_d    = 1'b1;
          end
          state_d = S_HOLD;
        end
      end

      // AW and W complete independently; leave once both have handshaken.
      S_WR_REQ: begin
        awvalid_o = !aw_done_q;
        wvalid_o  = !w_done_q;
        aw_done_d = aw_done_q || awready_i;
        w_done_d  = w_done_q || wready_i;
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end

      S_WR_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          err_d   = (bresp_i != RESP_OKAY);
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        valid_post_o = 1'b1;
        if (ready_post_i) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      size_q    <= '0;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      wen_in_q  <= 1'b0;
      result_q  <= '0;
      wb_wen_q  <= 1'b0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wen_in_q  <= wen_in_d;
      result_q  <= result_d;
      wb_wen_q  <= wb_wen_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// tb_lsu_controller
//   Directed bench. The stimulus process drives execute, bus and commit
//   inputs cycle by cycle and checks bus-side outputs and latencies inline;
//   each issued instruction pushes its expected commit record into a queue
//   that a separate monitor pops on every commit handshake.
module tb_lsu_controller;

  logic        clock, reset;
  logic        valid_pre_i, ready_pre_o;
  logic [1:0]  inst_type_i, mem_size_i;
  logic        load_unsigned_i;
  logic [31:0] addr_i, alu_result_i, wdata_i;
  logic [4:0]  rd_i;
  logic        wen_i;
  logic [31:0] araddr_o;
  logic        arvalid_o, arready_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rvalid_i, rready_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o, awready_i;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wvalid_o, wready_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i, bready_o;
  logic        valid_post_o, ready_post_i;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        wen_o, mem_err_o;

  lsu_controller dut (
    .clock(clock), .reset(reset),
    .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
    .inst_type_i(inst_type_i), .mem_size_i(mem_size_i),
    .load_unsigned_i(load_unsigned_i), .addr_i(addr_i),
    .alu_result_i(alu_result_i), .wdata_i(wdata_i), .rd_i(rd_i), .wen_i(wen_i),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
    .result_o(result_o), .rd_o(rd_o), .wen_o(wen_o), .mem_err_o(mem_err_o)
  );

  typedef struct {
    logic [31:0] result;
    logic        chk_res;   // stores have no defined writeback value
    logic [4:0]  rd;
    logic        wen;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_commit(input logic [31:0] res, input logic chk, input logic [4:0] rd,
                               input logic wen, input logic err);
    exp_t e;
    e.result = res; e.chk_res = chk; e.rd = rd; e.wen = wen; e.err = err;
    sb.push_back(e);
  endtask

  // Presents one instruction for a single cycle; returns just after the accept edge.
  task automatic issue(input logic [1:0] t, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rd, input logic wen);
    check("ready_pre before issue", {31'h0, ready_pre_o}, 32'h1);
    inst_type_i = t; mem_size_i = sz; load_unsigned_i = uns; addr_i = addr;
    alu_result_i = alu; wdata_i = wd; rd_i = rd; wen_i = wen;
    valid_pre_i = 1'b1;
    tick();
    valid_pre_i = 1'b0;
  endtask

  // Monitor: compares every commit handshake against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && valid_post_o && ready_post_i) begin
        if (sb.size() == 0) begin
          check("unexpected commit", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          if (e.chk_res) check("commit result", result_o, e.result);
          check("commit rd", {27'h0, rd_o}, {27'h0, e.rd});
          check("commit wen", {31'h0, wen_o}, {31'h0, e.wen});
          check("commit err", {31'h0, mem_err_o}, {31'h0, e.err});
        end
      end
    end
  end

  initial begin
    reset = 1'b1; valid_pre_i = 1'b0; inst_type_i = 2'b00; mem_size_i = 2'b00;
    load_unsigned_i = 1'b0; addr_i = '0; alu_result_i = '0; wdata_i = '0;
    rd_i = '0; wen_i = 1'b0; arready_i = 1'b0; rdata_i = '0; rresp_i = 2'b00;
    rvalid_i = 1'b0; awready_i = 1'b0; wready_i = 1'b0; bresp_i = 2'b00;
    bvalid_i = 1'b0; ready_post_i = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst ready_pre", {31'h0, ready_pre_o}, 32'h1);
    check("rst valid_post", {31'h0, valid_post_o}, 32'h0);
    check("rst bus valids", {28'h0, arvalid_o, rready_o, awvalid_o, wvalid_o}, 32'h0);
    check("rst bready", {31'h0, bready_o}, 32'h0);
    check("rst outputs", {result_o[31:8], result_o[7:0] | {rd_o, wen_o, mem_err_o, 1'b0}}, 32'h0);

    // ALU passthrough: result one cycle after accept
    expect_commit(32'h1234, 1'b1, 5'd5, 1'b1, 1'b0);
    issue(2'b00, 2'b10, 1'b0, 32'h0, 32'h1234, 32'h0, 5'd5, 1'b1);
    check("alu valid_post N+1", {31'h0, valid_post_o}, 32'h1);
    check("alu no arvalid", {31'h0, arvalid_o}, 32'h0);
    tick();

    // Reserved type behaves as ALU
    expect_commit(32'hCAFEF00D, 1'b1, 5'd31, 1'b0, 1'b0);
    issue(2'b11, 2'b00, 1'b0, 32'h3, 32'hCAFEF00D, 32'h0, 5'd31, 1'b0);
    check("rsvd valid_post N+1", {31'h0, valid_post_o}, 32'h1);
    tick();

    // Load byte signed at offset 3, zero-wait bus
    expect_commit(32'hFFFFFF80, 1'b1, 5'd7, 1'b1, 1'b0);
    issue(2'b01, 2'b00, 1'b0, 32'h80000003, 32'h0, 32'h0, 5'd7, 1'b1);
    check("ldb arvalid N+1", {31'h0, arvalid_o}, 32'h1);
    check("ldb araddr", araddr_o, 32'h80000000);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    check("ldb arvalid drop", {31'h0, arvalid_o}, 32'h0);
    check("ldb rready", {31'h0, rready_o}, 32'h1);
    rvalid_i = 1'b1; rdata_i = 32'h80FF0000;
    tick();
    rvalid_i = 1'b0;
    check("ldb valid_post N+3", {31'h0, valid_post_o}, 32'h1);
    tick();

    // Load half unsigned at offset 2
    expect_commit(32'h0000F00D, 1'b1, 5'd9, 1'b1, 1'b0);
    issue(2'b01, 2'b01, 1'b1, 32'h00000202, 32'h0, 32'h0, 5'd9, 1'b1);
    check("ldh araddr", araddr_o, 32'h00000200);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    rvalid_i = 1'b1; rdata_i = 32'hF00D1234;
    tick();
    rvalid_i = 1'b0;
    tick();

    // Store half at offset 2, awready two cycles after wready
    expect_commit(32'h0, 1'b0, 5'd3, 1'b0, 1'b0);
    issue(2'b10, 2'b01, 1'b0, 32'h80000002, 32'h0, 32'h0000ABCD, 5'd3, 1'b1);
    check("sth aw/w valid N+1", {30'h0, awvalid_o, wvalid_o}, 32'h3);
    check("sth wdata", wdata_o, 32'hABCD0000);
    check("sth wstrb", {28'h0, wstrb_o}, 32'hC);
    check("sth awaddr", awaddr_o, 32'h80000000);
    wready_i = 1'b1;
    tick();
    wready_i = 1'b0;
    check("sth w dropped", {30'h0, awvalid_o, wvalid_o}, 32'h2);
    check("sth no bready 1", {31'h0, bready_o}, 32'h0);
    tick();
    check("sth aw held", {30'h0, awvalid_o, wvalid_o}, 32'h2);
    check("sth no bready 2", {31'h0, bready_o}, 32'h0);
    awready_i = 1'b1;
    tick();
    awready_i = 1'b0;
    check("sth bready", {31'h0, bready_o}, 32'h1);
    check("sth aw dropped", {31'h0, awvalid_o}, 32'h0);
    bvalid_i = 1'b1;
    tick();
    bvalid_i = 1'b0;
    check("sth valid_post", {31'h0, valid_post_o}, 32'h1);
    tick();

    // Store byte at offset 1 with error response
    expect_commit(32'h0, 1'b0, 5'd4, 1'b0, 1'b1);
    issue(2'b10, 2'b00, 1'b0, 32'h80000001, 32'h0, 32'h0000005A, 5'd4, 1'b1);
    check("stb wdata", wdata_o, 32'h00005A00);
    check("stb wstrb", {28'h0, wstrb_o}, 32'h2);
    awready_i = 1'b1; wready_i = 1'b1;
    tick();
    awready_i = 1'b0; wready_i = 1'b0;
    check("stb bready", {31'h0, bready_o}, 32'h1);
    bvalid_i = 1'b1; bresp_i = 2'b10;
    tick();
    bvalid_i = 1'b0; bresp_i = 2'b00;
    tick();

    // Misaligned word load: no bus traffic, error next cycle
    expect_commit(32'h0, 1'b0, 5'd6, 1'b0, 1'b1);
    issue(2'b01, 2'b10, 1'b0, 32'h80000001, 32'h0, 32'h0, 5'd6, 1'b1);
    check("misld no arvalid", {31'h0, arvalid_o}, 32'h0);
    check("misld valid_post N+1", {31'h0, valid_post_o}, 32'h1);
    tick();

    // Misaligned half store: no bus traffic
    expect_commit(32'h0, 1'b0, 5'd8, 1'b0, 1'b1);
    issue(2'b10, 2'b01, 1'b0, 32'h00000003, 32'h0, 32'h1111, 5'd8, 1'b1);
    check("misst no aw/w", {30'h0, awvalid_o, wvalid_o}, 32'h0);
    check("misst valid_post", {31'h0, valid_post_o}, 32'h1);
    tick();

    // Load with SLVERR, commit stalls 4 cycles
    ready_post_i = 1'b0;
    expect_commit(32'h0, 1'b1, 5'd10, 1'b0, 1'b1);
    issue(2'b01, 2'b10, 1'b0, 32'h00000100, 32'h0, 32'h0, 5'd10, 1'b1);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    rvalid_i = 1'b1; rdata_i = 32'hDEADBEEF; rresp_i = 2'b10;
    tick();
    rvalid_i = 1'b0; rresp_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      check("stall valid_post", {31'h0, valid_post_o}, 32'h1);
      check("stall ready_pre", {31'h0, ready_pre_o}, 32'h0);
      check("stall result", result_o, 32'h0);
      check("stall err/wen", {30'h0, mem_err_o, wen_o}, 32'h2);
      tick();
    end
    ready_post_i = 1'b1;
    tick();
    check("stall released", {31'h0, ready_pre_o}, 32'h1);

    // Reset during RD_DATA abandons the read
    issue(2'b01, 2'b10, 1'b0, 32'h00000040, 32'h0, 32'h0, 5'd2, 1'b1);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    check("rdrst rready before", {31'h0, rready_o}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rdrst rready", {31'h0, rready_o}, 32'h0);
    check("rdrst ready_pre", {31'h0, ready_pre_o}, 32'h1);
    check("rdrst valid_post", {31'h0, valid_post_o}, 32'h0);

    // Stray rvalid/bvalid in IDLE are ignored
    rvalid_i = 1'b1; bvalid_i = 1'b1;
    tick();
    rvalid_i = 1'b0; bvalid_i = 1'b0;
    check("stray ready_pre", {31'h0, ready_pre_o}, 32'h1);
    check("stray valid_post", {31'h0, valid_post_o}, 32'h0);
    tick();

    check("scoreboard drained", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
